i2s_tdm_tx: RTL and testbench

I2S_TDM_TX -- requirements
Module: i2s_tdm_tx

---
 rtl/i2s_tdm_tx.sv | 170 +++++++++++++++++
 tb/tb_i2s_tdm_tx.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tdm_tx.sv
// i2s_tdm_tx: serial audio transmitter for I2S, left-justified and TDM (DSP mode A).
// The serial bit clock and word select are external and asynchronous; both are
// resynchronised into clk and every action happens on a detected sck falling edge.
// Optional feature: define I2S_TDM_TX_UNDERFLOW_CNT_EN to add the underflow_cnt output.
module i2s_tdm_tx #(
   parameter int AUDIO_DW = 8,
   parameter int NUM_CH   = 2,
   parameter int MODE     = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       sck_i,
   input  logic                       ws_i,
   input  logic [NUM_CH*AUDIO_DW-1:0] s_data,
   input  logic                       s_valid,
   output logic                       s_ready,
   output logic                       sd_o,
   output logic                       frame_start,
   output logic                       underflow
`ifdef I2S_TDM_TX_UNDERFLOW_CNT_EN
   ,
   output logic [7:0]                 underflow_cnt
`endif
);

   localparam int FW  = NUM_CH * AUDIO_DW;
   // A "run" is the stretch of bits sent after one boundary: one channel for
   // I2S / left-justified, the whole back-to-back slot train for TDM.
   localparam int RUN = (MODE == 2) ? FW : AUDIO_DW;
   localparam int BW  = $clog2(FW + 1);
   localparam logic [BW-1:0] RUN_LEN = BW'(RUN);
   localparam logic [BW-1:0] ONE     = BW'(1);

   logic          sck_meta_reg, sck_sync_reg, sck_dly_reg;
   logic          ws_meta_reg, ws_sync_reg;
   logic          ws_prev_reg;
   logic          framed_reg;
   logic          hold_full_reg;
   logic [FW-1:0] hold_data_reg;
   logic [FW-1:0] frame_reg;
   logic [FW-1:0] shift_reg;
   logic [BW-1:0] bits_left_reg;
   logic [FW-1:0] load_data;
   logic [FW-1:0] run_data;
   logic          fall_evt;
   logic          frame_bnd;
   logic          ch1_bnd;

   // Two-flop synchronisers for sck and ws, plus one extra sck stage for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         sck_meta_reg <= 1'b0;
         sck_sync_reg <= 1'b0;
         sck_dly_reg  <= 1'b0;
         ws_meta_reg  <= 1'b0;
         ws_sync_reg  <= 1'b0;
      end else begin
         sck_meta_reg <= sck_i;
         sck_sync_reg <= sck_meta_reg;
         sck_dly_reg  <= sck_sync_reg;
         ws_meta_reg  <= ws_i;
         ws_sync_reg  <= ws_meta_reg;
      end
   end

   assign fall_evt = sck_dly_reg & ~sck_sync_reg;

   // Classify a ws change seen at a fall event; channel-1 boundaries are ignored
   // until a frame start has been seen so no half frame leaks out after reset.
   always_comb begin
      frame_bnd = 1'b0;
      ch1_bnd   = 1'b0;
      if (fall_evt && (ws_sync_reg != ws_prev_reg)) begin
         if (MODE == 0) begin
            frame_bnd = ~ws_sync_reg;
            ch1_bnd   = ws_sync_reg & framed_reg;
         end else if (MODE == 1) begin
            frame_bnd = ws_sync_reg;
            ch1_bnd   = ~ws_sync_reg & framed_reg;
         end else begin
            frame_bnd = ws_sync_reg;
         end
      end
   end

   // An empty holding register at a frame start sends silence.
   assign load_data = hold_full_reg ? hold_data_reg : '0;
   // Channel 1 is realigned from the stored frame so a truncated channel 0 cannot skew it.
   assign run_data  = frame_bnd ? load_data : (frame_reg << AUDIO_DW);

   // One-entry holding register; a transfer in the same clk as a load refills it.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_full_reg <= 1'b0;
         hold_data_reg <= '0;
      end else begin
         if (s_valid && !hold_full_reg) begin
            hold_data_reg <= s_data;
            hold_full_reg <= 1'b1;
         end else if (frame_bnd) begin
            hold_full_reg <= 1'b0;
         end
      end
   end

   assign s_ready = ~hold_full_reg;

   // Serializer: one bit per fall event, MSB first, realigned at every boundary.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_reg     <= '0;
         frame_reg     <= '0;
         bits_left_reg <= '0;
         ws_prev_reg   <= 1'b0;
         framed_reg    <= 1'b0;
         sd_o          <= 1'b0;
         frame_start   <= 1'b0;
      end else begin
         frame_start <= frame_bnd;
         if (fall_evt) begin
            ws_prev_reg <= ws_sync_reg;
            if (frame_bnd || ch1_bnd) begin
               if (frame_bnd) begin
                  frame_reg  <= load_data;
                  framed_reg <= 1'b1;
               end
               if (MODE == 1) begin
                  // Left-justified: the MSB goes out on the boundary itself.
                  sd_o          <= run_data[FW-1];
                  shift_reg     <= run_data << 1;
                  bits_left_reg <= RUN_LEN - ONE;
               end else begin
                  // One-bit delay: the boundary slot still carries the tail of the
                  // previous run (if any); the new MSB follows on the next fall.
                  sd_o          <= (bits_left_reg != '0) & shift_reg[FW-1];
                  shift_reg     <= run_data;
                  bits_left_reg <= RUN_LEN;
               end
            end else if (bits_left_reg != '0) begin
               sd_o          <= shift_reg[FW-1];
               shift_reg     <= shift_reg << 1;
               bits_left_reg <= bits_left_reg - ONE;
            end else begin
               sd_o <= 1'b0;
            end
         end
      end
   end

   // Sticky underflow: a frame start found nothing to send.
   always_ff @(posedge clk) begin
      if (rst) begin
         underflow <= 1'b0;
      end else if (frame_bnd && !hold_full_reg) begin
         underflow <= 1'b1;
      end
   end

`ifdef I2S_TDM_TX_UNDERFLOW_CNT_EN
   // Saturating count of underflow events.
   always_ff @(posedge clk) begin
      if (rst) begin
         underflow_cnt <= 8'd0;
      end else if (frame_bnd && !hold_full_reg && (underflow_cnt != 8'hFF)) begin
         underflow_cnt <= underflow_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// tb_i2s_tdm_tx: scoreboard bench for i2s_tdm_tx. Three instances (I2S, left-justified,
// 4-channel TDM) each get their own sck/ws; expected slots are queued when data is
// pushed and popped as the serial output is reassembled.
module tb_i2s_tdm_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [2:0]  sck, ws, vld;
   wire  [2:0]  rdy, sd, fs, uf;
   logic [15:0] data0, data1;
   logic [31:0] data2;
`ifdef I2S_TDM_TX_UNDERFLOW_CNT_EN
   wire  [7:0]  cnt0, cnt1, cnt2;
`endif

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];
   int fs_cnt [3] = '{default: 0};

   i2s_tdm_tx #(.AUDIO_DW(8), .NUM_CH(2), .MODE(0)) u_i2s (
      .clk(clk), .rst(rst), .sck_i(sck[0]), .ws_i(ws[0]), .s_data(data0), .s_valid(vld[0]),
      .s_ready(rdy[0]), .sd_o(sd[0]), .frame_start(fs[0]), .underflow(uf[0])
`ifdef I2S_TDM_TX_UNDERFLOW_CNT_EN
      , .underflow_cnt(cnt0)
`endif
   );

   i2s_tdm_tx #(.AUDIO_DW(8), .NUM_CH(2), .MODE(1)) u_lj (
      .clk(clk), .rst(rst), .sck_i(sck[1]), .ws_i(ws[1]), .s_data(data1), .s_valid(vld[1]),
      .s_ready(rdy[1]), .sd_o(sd[1]), .frame_start(fs[1]), .underflow(uf[1])
`ifdef I2S_TDM_TX_UNDERFLOW_CNT_EN
      , .underflow_cnt(cnt1)
`endif
   );

   i2s_tdm_tx #(.AUDIO_DW(8), .NUM_CH(4), .MODE(2)) u_tdm (
      .clk(clk), .rst(rst), .sck_i(sck[2]), .ws_i(ws[2]), .s_data(data2), .s_valid(vld[2]),
      .s_ready(rdy[2]), .sd_o(sd[2]), .frame_start(fs[2]), .underflow(uf[2])
`ifdef I2S_TDM_TX_UNDERFLOW_CNT_EN
      , .underflow_cnt(cnt2)
`endif
   );

   // Count frame_start pulses per instance.
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++)
         if (fs[k]) fs_cnt[k] <= fs_cnt[k] + 1;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One sck period; ws is set well before the falling edge, sd_o is stable on return.
   task automatic fall(input int k, input logic w);
      ws[k] = w;
      #20 sck[k] = 1'b1;
      #40 sck[k] = 1'b0;
      #40;
   endtask

   task automatic push_exp(input int k, input logic [31:0] val);
      if (k == 2) begin
         exp_q.push_back(val[31:24]);
         exp_q.push_back(val[23:16]);
         exp_q.push_back(val[15:8]);
         exp_q.push_back(val[7:0]);
      end else begin
         exp_q.push_back(val[15:8]);
         exp_q.push_back(val[7:0]);
      end
   endtask

   task automatic push_frame(input int k, input logic [31:0] val);
      int t;
      t = 0;
      @(negedge clk);
      while (!rdy[k] && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (!rdy[k]) begin
         check_value("push_timeout", {31'd0, rdy[k]}, 32'd1);
         return;
      end
      case (k)
         0:       data0 = val[15:0];
         1:       data1 = val[15:0];
         default: data2 = val;
      endcase
      vld[k] = 1'b1;
      @(posedge clk);
      #1 vld[k] = 1'b0;
      push_exp(k, val);
   endtask

   // Drive one frame of ws on instance k, reassemble its slots and score them.
   task automatic run_frame(input int k);
      int         len, nsl, st, fs0;
      logic [7:0] acc [4];
      logic [7:0] e;
      logic       stray, in_slot, w;
      len   = (k == 2) ? 36 : 24;
      nsl   = (k == 2) ? 4 : 2;
      stray = 1'b0;
      fs0   = fs_cnt[k];
      for (int s = 0; s < 4; s++) acc[s] = 8'h00;
      for (int f = 0; f < len; f++) begin
         case (k)
            0:       w = (f >= 12);
            1:       w = (f < 12);
            default: w = (f == 0);
         endcase
         fall(k, w);
         in_slot = 1'b0;
         for (int s = 0; s < nsl; s++) begin
            st = (k == 2) ? (1 + 8 * s) : (12 * s + ((k == 1) ? 0 : 1));
            if (f >= st && f < st + 8) begin
               acc[s]  = {acc[s][6:0], sd[k]};
               in_slot = 1'b1;
            end
         end
         if (!in_slot) stray = stray | sd[k];
      end
      check_value($sformatf("gap_zero_k%0d", k), {31'd0, stray}, 32'd0);
      check_value($sformatf("frame_start_k%0d", k), fs_cnt[k] - fs0, 32'd1);
      for (int s = 0; s < nsl; s++) begin
         if (exp_q.size() == 0) begin
            check_value($sformatf("sb_empty_k%0d", k), exp_q.size(), 32'd1);
         end else begin
            e = exp_q.pop_front();
            $display("frame k=%0d slot %0d: got %02h exp %02h", k, s, acc[s], e);
            check_value($sformatf("slot_k%0d_s%0d", k, s), {24'd0, acc[s]}, {24'd0, e});
         end
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      sck = 3'b000;
      ws  = 3'b000;
      vld = 3'b000;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
   endtask

   logic [15:0] vals [4] = '{16'h1122, 16'h3344, 16'h5566, 16'h7788};
   logic        feed_done;
   int          rdy_cnt, run_len, max_run;
   logic        stray;

   initial begin
      rst   = 1'b1;
      sck   = 3'b000;
      ws    = 3'b000;
      vld   = 3'b000;
      data0 = '0;
      data1 = '0;
      data2 = '0;
      apply_reset();

      // Reset state
      check_value("rst_ready", {29'd0, rdy}, 32'd7);
      check_value("rst_sd", {29'd0, sd}, 32'd0);
      check_value("rst_fs", {29'd0, fs}, 32'd0);
      check_value("rst_uf", {29'd0, uf}, 32'd0);
`ifdef I2S_TDM_TX_UNDERFLOW_CNT_EN
      check_value("rst_cnt", {8'd0, cnt0, cnt1, cnt2}, 32'd0);
`endif

      // Prime I2S ws high: a channel-1 edge before any frame start must emit nothing.
      fall(0, 1'b1);
      check_value("prime_sd", {31'd0, sd[0]}, 32'd0);

      // Underflow across three frames
      for (int i = 0; i < 3; i++) begin
         push_exp(0, 32'd0);
         run_frame(0);
      end
      check_value("underflow_set", {31'd0, uf[0]}, 32'd1);
`ifdef I2S_TDM_TX_UNDERFLOW_CNT_EN
      check_value("underflow_cnt", {24'd0, cnt0}, 32'd3);
`endif

      // I2S data, underflow stays sticky
      push_frame(0, 32'h0000A53C);
      run_frame(0);
      check_value("underflow_sticky", {31'd0, uf[0]}, 32'd1);

      // Left-justified
      push_frame(1, 32'h0000A53C);
      run_frame(1);
      check_value("lj_no_underflow", {31'd0, uf[1]}, 32'd0);

      // TDM, four slots
      push_frame(2, 32'h11223344);
      run_frame(2);
      check_value("tdm_no_underflow", {31'd0, uf[2]}, 32'd0);

      // s_valid held high across frames
      feed_done = 1'b0;
      rdy_cnt   = 0;
      run_len   = 0;
      max_run   = 0;
      fork
         begin
            int t;
            for (int i = 0; i < 4; i++) begin
               data0  = vals[i];
               vld[0] = 1'b1;
               t = 0;
               @(negedge clk);
               while (!rdy[0] && t < 20000) begin
                  @(negedge clk);
                  t++;
               end
               if (!rdy[0]) begin
                  check_value("feed_timeout", {31'd0, rdy[0]}, 32'd1);
                  break;
               end
               push_exp(0, {16'd0, vals[i]});
               @(posedge clk);
               #1;
            end
            vld[0]    = 1'b0;
            feed_done = 1'b1;
         end
         begin
            while (!feed_done) begin
               @(negedge clk);
               if (vld[0] && rdy[0]) begin
                  rdy_cnt++;
                  run_len++;
                  if (run_len > max_run) max_run = run_len;
               end else begin
                  run_len = 0;
               end
            end
         end
         begin
            repeat (4) run_frame(0);
         end
      join
      check_value("ready_clks_total", rdy_cnt, 32'd4);
      check_value("ready_max_run", max_run, 32'd1);

      // Reset in the middle of a slot
      push_frame(0, 32'h0000FFFF);
      fall(0, 1'b0);
      push_frame(0, 32'h00001234);
      for (int f = 1; f <= 4; f++) fall(0, 1'b0);
      check_value("pre_rst_sd", {31'd0, sd[0]}, 32'd1);
      check_value("pre_rst_ready", {31'd0, rdy[0]}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_value("rst_mid_sd", {31'd0, sd[0]}, 32'd0);
      check_value("rst_mid_ready", {31'd0, rdy[0]}, 32'd1);
      rst = 1'b0;
      exp_q.delete();
      push_frame(0, 32'h00005AC3);
      stray = 1'b0;
      for (int f = 5; f < 12; f++) begin
         fall(0, 1'b0);
         stray = stray | sd[0];
      end
      for (int f = 0; f < 12; f++) begin
         fall(0, 1'b1);
         stray = stray | sd[0];
      end
      check_value("no_emit_after_rst", {31'd0, stray}, 32'd0);
      run_frame(0);
      check_value("uf_cleared_by_rst", {31'd0, uf[0]}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
